// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku board command path.
// Used by board_cmd_arbiter and its edit-command FIFO.
package sudoku_pkg;

  localparam int          CELLS         = 81;
  localparam int          N             = 9;
  localparam logic [6:0]  CURSOR_CENTER = 7'd40;
  localparam logic [13:0] OP_COUNT_MAX  = 14'd9999;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    LOAD
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [3:0] data;
  } edit_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of edit commands with flush.
// Ports: i_clk/i_rst_n (sync, active-low), i_push/i_push_data,
//   i_pop, i_flush, o_head (head entry), o_full, o_empty.
//   A push while full is accepted when a pop happens in the same cycle.
module cmd_fifo
  import sudoku_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  edit_cmd_t i_push_data,
  input  logic      i_pop,
  input  logic      i_flush,
  output edit_cmd_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  edit_cmd_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/board_cmd_arbiter.sv
// Arbiter between player inputs and the board's single write port.
// Ports: CLK_100MHz, RST_n (sync, active-low); init_tag, game_over,
//   btn_*, num_valid/num_code, read_only in; cursor, wr_req/addr/data,
//   load_req, op_counter, busy, overflow out; wr_ack, load_ack in.
module board_cmd_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CELLS      = 81,
  parameter int N          = 9
) (
  input  logic             CLK_100MHz,
  input  logic             RST_n,
  input  logic             init_tag,
  input  logic             game_over,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_center,
  input  logic             num_valid,
  input  logic [3:0]       num_code,
  input  logic [CELLS-1:0] read_only,
  output logic [6:0]       cursor,
  output logic             wr_req,
  output logic [6:0]       wr_addr,
  output logic [3:0]       wr_data,
  input  logic             wr_ack,
  output logic             load_req,
  input  logic             load_ack,
  output logic [13:0]      op_counter,
  output logic             busy,
  output logic             overflow
);

  import sudoku_pkg::*;

  localparam logic [6:0] L_N     = 7'(N);
  localparam logic [6:0] L_LAST  = 7'(N - 1);
  localparam logic [6:0] L_WRAP  = 7'(N * (N - 1));
  localparam logic [6:0] L_ROW8  = 7'(CELLS - N);

  state_t     r_state;
  logic       r_init_q;
  logic       r_pending;
  logic [6:0] r_cursor;
  logic       r_wr_req;
  logic [6:0] r_wr_addr;
  logic [3:0] r_wr_data;
  logic       r_load_req;
  logic [13:0] r_op_cnt;
  logic       r_overflow;

  logic       w_init_rise;
  logic       w_load_go;
  logic       w_in_load;
  logic       w_accept;
  logic       w_num_ok;
  logic       w_edit;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [6:0] w_col;
  edit_cmd_t  w_cmd;
  edit_cmd_t  w_head;

  assign w_init_rise = init_tag && !r_init_q;
  assign w_load_go   = (r_state == IDLE) && (w_init_rise || r_pending);
  assign w_in_load   = (r_state == LOAD);
  assign w_accept    = !game_over && !w_in_load;
  assign w_num_ok    = num_valid && (num_code != 4'd0)
                    && (num_code <= 4'd9);
  assign w_edit      = w_accept && (btn_center || w_num_ok)
                    && !read_only[r_cursor];
  assign w_cmd.addr  = r_cursor;
  assign w_cmd.data  = btn_center ? 4'd0 : num_code;
  assign w_pop       = (r_state == WAIT_ACK) && wr_ack;
  assign w_col       = r_cursor % L_N;

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (CLK_100MHz),
    .i_rst_n    (RST_n),
    .i_push     (w_edit),
    .i_push_data(w_cmd),
    .i_pop      (w_pop),
    .i_flush    (w_in_load),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge CLK_100MHz) begin
    if (!RST_n) r_init_q <= 1'b0;
    else        r_init_q <= init_tag;
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!RST_n || w_load_go || w_in_load) begin
      r_cursor <= CURSOR_CENTER;
    end else if (w_accept) begin
      priority case (1'b1)
        btn_up:
          r_cursor <= (r_cursor < L_N) ? r_cursor + L_WRAP
                                       : r_cursor - L_N;
        btn_down:
          r_cursor <= (r_cursor >= L_ROW8) ? r_cursor - L_WRAP
                                           : r_cursor + L_N;
        btn_left:
          r_cursor <= (w_col == 7'd0) ? r_cursor + L_LAST
                                      : r_cursor - 7'd1;
        btn_right:
          r_cursor <= (w_col == L_LAST) ? r_cursor - L_LAST
                                        : r_cursor + 7'd1;
        default:
          r_cursor <= r_cursor;
      endcase
    end
  end

  // a full FIFO still takes the edit when the head pops this cycle
  always_ff @(posedge CLK_100MHz) begin
    if (!RST_n || w_load_go || w_in_load) begin
      r_overflow <= 1'b0;
    end else if (w_edit && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!RST_n) begin
      r_state    <= IDLE;
      r_pending  <= 1'b0;
      r_wr_req   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_load_req <= 1'b0;
      r_op_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_init_rise || r_pending) begin
            r_state    <= LOAD;
            r_pending  <= 1'b0;
            r_load_req <= 1'b1;
            r_op_cnt   <= '0;
          end else if (!w_empty) begin
            r_state   <= ISSUE;
            r_wr_req  <= 1'b1;
            r_wr_addr <= w_head.addr;
            r_wr_data <= w_head.data;
          end
        end
        ISSUE: begin
          if (w_init_rise) r_pending <= 1'b1;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (w_init_rise) r_pending <= 1'b1;
          if (wr_ack) begin
            r_wr_req <= 1'b0;
            r_state  <= IDLE;
            if (r_wr_data != 4'd0) begin
              r_op_cnt <= (r_op_cnt == OP_COUNT_MAX) ? '0
                                                     : r_op_cnt + 1'b1;
            end
          end
        end
        LOAD: begin
          r_op_cnt <= '0;
          if (load_ack) begin
            r_load_req <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cursor     = r_cursor;
  assign wr_req     = r_wr_req;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign load_req   = r_load_req;
  assign op_counter = r_op_cnt;
  assign overflow   = r_overflow;
  assign busy       = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_board_cmd_arbiter.sv
// Directed bench for board_cmd_arbiter.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_board_cmd_arbiter;

  logic        clk = 1'b0;
  logic        RST_n = 1'b0;
  logic        init_tag = 1'b0;
  logic        game_over = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_center = 1'b0;
  logic        num_valid = 1'b0;
  logic [3:0]  num_code = 4'd0;
  logic [80:0] read_only = '0;
  logic [6:0]  cursor;
  logic        wr_req;
  logic [6:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ack = 1'b0;
  logic        load_req;
  logic        load_ack = 1'b0;
  logic [13:0] op_counter;
  logic        busy;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  board_cmd_arbiter #(
    .FIFO_DEPTH(4),
    .CELLS(81),
    .N(9)
  ) dut (
    .CLK_100MHz(clk),
    .RST_n     (RST_n),
    .init_tag  (init_tag),
    .game_over (game_over),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_center(btn_center),
    .num_valid (num_valid),
    .num_code  (num_code),
    .read_only (read_only),
    .cursor    (cursor),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .load_req  (load_req),
    .load_ack  (load_ack),
    .op_counter(op_counter),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    repeat (3) @(negedge clk);
    RST_n = 1'b1;
  endtask

  task automatic press(input int b);
    case (b)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_left = 1'b1;
      default: btn_right = 1'b1;
    endcase
    @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
  endtask

  task automatic press_num(input logic [3:0] c);
    num_valid = 1'b1;
    num_code = c;
    @(negedge clk);
    num_valid = 1'b0;
    num_code = 4'd0;
  endtask

  task automatic wait_wr();
    int n = 0;
    while (!wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!wr_req) chk("wr_req_timeout", 32'(wr_req), 1);
  endtask

  task automatic wait_ld();
    int n = 0;
    while (!load_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!load_req) chk("load_req_timeout", 32'(load_req), 1);
  endtask

  task automatic ack_wr();
    wait_wr();
    @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
  endtask

  initial begin
    int up_exp [5];
    up_exp = '{31, 22, 13, 4, 76};

    // reset values
    do_reset();
    RST_n = 1'b0;
    @(negedge clk);
    chk("rst_cursor", 32'(cursor), 40);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_load_req", 32'(load_req), 0);
    chk("rst_op", 32'(op_counter), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    RST_n = 1'b1;
    @(negedge clk);

    // up wrap from row 0
    for (int i = 0; i < 5; i++) begin
      press(0);
      chk("up_cursor", 32'(cursor), 32'(up_exp[i]));
    end

    // right wrap from column 8
    do_reset();
    repeat (4) press(3);
    chk("right_44", 32'(cursor), 44);
    press(3);
    chk("right_wrap", 32'(cursor), 36);
    press(2);
    chk("left_wrap", 32'(cursor), 44);
    press(1);
    chk("down", 32'(cursor), 53);
    repeat (2) press(0);
    chk("up2", 32'(cursor), 35);

    // move to cell 10: 35 -> 26 -> 17 -> 8 -> wrap right to 0 -> 9 -> 10
    repeat (3) press(0);
    press(3);
    press(1);
    press(3);
    chk("cursor_10", 32'(cursor), 10);

    // single digit write
    press_num(4'd5);
    chk("busy_q", 32'(busy), 1);
    wait_wr();
    chk("w1_addr", 32'(wr_addr), 10);
    chk("w1_data", 32'(wr_data), 5);
    @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    chk("w1_req_drop", 32'(wr_req), 0);
    chk("w1_op", 32'(op_counter), 1);

    // locked cell ignored
    read_only[10] = 1'b1;
    press_num(4'd5);
    repeat (4) @(negedge clk);
    chk("ro_no_req", 32'(wr_req), 0);
    chk("ro_busy", 32'(busy), 0);
    read_only[10] = 1'b0;

    // out-of-range digit ignored
    press_num(4'd12);
    repeat (4) @(negedge clk);
    chk("bad_code_busy", 32'(busy), 0);

    // center wins over digit
    btn_center = 1'b1;
    num_valid = 1'b1;
    num_code = 4'd7;
    @(negedge clk);
    btn_center = 1'b0;
    num_valid = 1'b0;
    num_code = 4'd0;
    wait_wr();
    chk("clr_addr", 32'(wr_addr), 10);
    chk("clr_data", 32'(wr_data), 0);
    @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    chk("clr_op", 32'(op_counter), 1);
    repeat (4) @(negedge clk);
    chk("clr_single", 32'(busy), 0);

    // six edits with no acks: four held, overflow
    for (int i = 1; i <= 6; i++) begin
      num_valid = 1'b1;
      num_code = 4'(i);
      @(negedge clk);
    end
    num_valid = 1'b0;
    num_code = 4'd0;
    chk("ovf_set", 32'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      wait_wr();
      chk("ord_data", 32'(wr_data), 32'(i));
      chk("ord_addr", 32'(wr_addr), 10);
      @(negedge clk);
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("ord_drain", 32'(busy), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ord_op", 32'(op_counter), 5);

    // counter wrap
    for (int i = 0; i < 9994; i++) begin
      press_num(4'd7);
      ack_wr();
    end
    chk("op_max", 32'(op_counter), 9999);
    press_num(4'd3);
    ack_wr();
    chk("op_wrap", 32'(op_counter), 0);

    // game over blocks nav and edits
    game_over = 1'b1;
    press(0);
    press_num(4'd4);
    repeat (3) @(negedge clk);
    chk("go_cursor", 32'(cursor), 10);
    chk("go_busy", 32'(busy), 0);
    game_over = 1'b0;

    // reload during WAIT_ACK with three queued
    for (int i = 1; i <= 3; i++) begin
      num_valid = 1'b1;
      num_code = 4'(i);
      @(negedge clk);
    end
    num_valid = 1'b0;
    num_code = 4'd0;
    init_tag = 1'b1;
    chk("ld_cur_req", 32'(wr_req), 1);
    chk("ld_cur_data", 32'(wr_data), 1);
    @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    wait_ld();
    chk("ld_req", 32'(load_req), 1);
    chk("ld_wr_idle", 32'(wr_req), 0);
    chk("ld_cursor", 32'(cursor), 40);
    chk("ld_op", 32'(op_counter), 0);
    chk("ld_ovf", 32'(overflow), 0);
    chk("ld_busy", 32'(busy), 1);
    @(negedge clk);
    load_ack = 1'b1;
    @(negedge clk);
    load_ack = 1'b0;
    chk("ld_done", 32'(load_req), 0);
    repeat (5) @(negedge clk);
    chk("ld_flushed", 32'(busy), 0);
    chk("ld_no_wr", 32'(wr_req), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end

endmodule
